// File: rtl/ld_ext_pkg.sv
// rtl/ld_ext_pkg.sv - shared encodings for the load align/extend unit
package ld_ext_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  localparam int ERRW = 16;

endpackage

// File: rtl/ld_lane_extract.sv
// rtl/ld_lane_extract.sv - combinational lane select, extension and error detect
module ld_lane_extract
  import ld_ext_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit BIG_ENDIAN = 1'b0,
  localparam int OFFW      = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] data,
  input  logic [OFFW-1:0] off,
  input  logic [1:0]      size,
  input  logic            sext,
  output logic [XLEN-1:0] res,
  output logic            err
);

  int              nb;
  int              sh;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] fill;
  logic            msb;

  always_comb begin
    nb  = 1 << int'(size);
    err = ((int'(off) & (nb - 1)) != 0) || (size == SZ_D && XLEN == 32);
    sh  = 0;
    if (!err)
      sh = BIG_ENDIAN ? (XLEN/8 - nb - int'(off)) * 8 : int'(off) * 8;
    lane = data >> sh;
    mask = '1;
    if (nb * 8 < XLEN)
      mask = ~({XLEN{1'b1}} << (nb * 8));
    // top set bit of the mask marks the lane msb; full-width lanes leave no fill bits
    msb  = |(lane & (mask & ~(mask >> 1)));
    fill = (sext && msb) ? '1 : '0;
    res  = err ? '0 : ((lane & mask) | (fill & ~mask));
  end

endmodule

// File: rtl/ld_align_ext.sv
// rtl/ld_align_ext.sv - load data align/extend with output register and one-entry skid
module ld_align_ext
  import ld_ext_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit BIG_ENDIAN = 1'b0,
  localparam int OFFW      = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_data,
  input  logic [OFFW-1:0] in_off,
  input  logic [1:0]      in_size,
  input  logic            in_sext,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            out_err,
  output logic [ERRW-1:0] err_cnt
);

  occ_e            state;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [XLEN-1:0] skid_data;
  logic            skid_err;
  logic [XLEN-1:0] x_data;
  logic            x_err;
  logic            in_fire;
  logic            out_fire;

  ld_lane_extract #(.XLEN(XLEN), .BIG_ENDIAN(BIG_ENDIAN)) u_extract (
    .data (in_data),
    .off  (in_off),
    .size (in_size),
    .sext (in_sext),
    .res  (x_data),
    .err  (x_err)
  );

  // rst gating keeps requests from being accepted while the unit is held in reset
  assign in_ready  = in_ready_r & ~rst;
  assign out_valid = out_valid_r;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data    <= '0;
      out_err     <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (out_fire && out_err && err_cnt != '1)
        err_cnt <= err_cnt + ERRW'(1);
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_data    <= x_data;
            out_err     <= x_err;
            out_valid_r <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            out_data <= x_data;
            out_err  <= x_err;
          end else if (out_fire) begin
            out_valid_r <= 1'b0;
            state       <= ST_EMPTY;
          end else if (in_fire) begin
            skid_data  <= x_data;
            skid_err   <= x_err;
            in_ready_r <= 1'b0;
            state      <= ST_TWO;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            out_data   <= skid_data;
            out_err    <= skid_err;
            in_ready_r <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ld_align_ext.sv
// tb/tb_ld_align_ext.sv - scoreboard bench for ld_align_ext (32-bit LE and 64-bit BE)
module tb_ld_align_ext;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid32 = 1'b0, in_ready32, in_sext32 = 1'b0;
  logic [31:0] in_data32 = '0;
  logic [1:0]  in_off32 = '0, in_size32 = '0;
  logic        out_valid32, out_ready32 = 1'b1, out_err32;
  logic [31:0] out_data32;
  logic [15:0] err_cnt32;

  logic        in_valid64 = 1'b0, in_ready64, in_sext64 = 1'b0;
  logic [63:0] in_data64 = '0;
  logic [2:0]  in_off64 = '0;
  logic [1:0]  in_size64 = '0;
  logic        out_valid64, out_ready64 = 1'b1, out_err64;
  logic [63:0] out_data64;
  logic [15:0] err_cnt64;

  typedef struct {
    logic [63:0] d;
    logic        e;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ld_align_ext #(.XLEN(32), .BIG_ENDIAN(1'b0)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_off(in_off32), .in_size(in_size32), .in_sext(in_sext32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_data(out_data32),
    .out_err(out_err32), .err_cnt(err_cnt32)
  );

  ld_align_ext #(.XLEN(64), .BIG_ENDIAN(1'b1)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
    .in_data(in_data64), .in_off(in_off64), .in_size(in_size64), .in_sext(in_sext64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_data(out_data64),
    .out_err(out_err64), .err_cnt(err_cnt64)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send32(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                        input logic sx, input logic [31:0] ed, input logic ee);
    int n;
    n = 0;
    @(negedge clk);
    in_valid32 = 1'b1; in_data32 = d; in_off32 = off; in_size32 = sz; in_sext32 = sx;
    #4;
    while (!in_ready32 && n < 40) begin
      @(negedge clk); #4; n++;
    end
    if (!in_ready32) begin
      total++; bad++;
      $display("FAIL send32_timeout: got in_ready=0 want 1");
    end else begin
      q32.push_back('{64'(ed), ee});
    end
    @(negedge clk);
    in_valid32 = 1'b0;
  endtask

  task automatic send64(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                        input logic sx, input logic [63:0] ed, input logic ee);
    int n;
    n = 0;
    @(negedge clk);
    in_valid64 = 1'b1; in_data64 = d; in_off64 = off; in_size64 = sz; in_sext64 = sx;
    #4;
    while (!in_ready64 && n < 40) begin
      @(negedge clk); #4; n++;
    end
    if (!in_ready64) begin
      total++; bad++;
      $display("FAIL send64_timeout: got in_ready=0 want 1");
    end else begin
      q64.push_back('{ed, ee});
    end
    @(negedge clk);
    in_valid64 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    if (q32.size() != 0 || q64.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", q32.size() + q64.size());
    end
    @(negedge clk);
  endtask

  // monitor for the 32-bit unit: pops on every output transfer, checks hold while stalled
  initial begin
    logic        hold;
    logic [31:0] hd;
    logic        he;
    exp_t        e;
    hold = 1'b0; hd = '0; he = 1'b0;
    forever begin
      @(negedge clk); #4;
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold && out_valid32) begin
          chk("hold32_data", 64'(out_data32), 64'(hd));
          chk("hold32_err", 64'(out_err32), 64'(he));
        end
        if (out_valid32 && out_ready32) begin
          if (q32.size() == 0) begin
            total++; bad++;
            $display("FAIL out32_unexpected: got %h want no output", out_data32);
          end else begin
            e = q32.pop_front();
            chk("out32_data", 64'(out_data32), e.d);
            chk("out32_err", 64'(out_err32), 64'(e.e));
          end
        end
        hold = out_valid32 && !out_ready32;
        hd = out_data32; he = out_err32;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #4;
      if (!rst && out_valid64 && out_ready64) begin
        if (q64.size() == 0) begin
          total++; bad++;
          $display("FAIL out64_unexpected: got %h want no output", out_data64);
        end else begin
          e = q64.pop_front();
          chk("out64_data", out_data64, e.d);
          chk("out64_err", 64'(out_err64), 64'(e.e));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready32), 64'd0);
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_out_data", 64'(out_data32), 64'd0);
    chk("rst_out_err", 64'(out_err32), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt32), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready32), 64'd1);

    send32(32'h80FF_7F01, 2'd2, 2'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    send32(32'h80FF_7F01, 2'd2, 2'd0, 1'b0, 32'h0000_00FF, 1'b0);
    send32(32'h80FF_7F01, 2'd0, 2'd0, 1'b1, 32'h0000_0001, 1'b0);
    send32(32'h80FF_7F01, 2'd1, 2'd0, 1'b1, 32'h0000_007F, 1'b0);
    send32(32'h80FF_7F01, 2'd3, 2'd0, 1'b1, 32'hFFFF_FF80, 1'b0);
    send32(32'h8001_1234, 2'd2, 2'd1, 1'b0, 32'h0000_8001, 1'b0);
    send32(32'h8001_1234, 2'd2, 2'd1, 1'b1, 32'hFFFF_8001, 1'b0);
    send32(32'h8001_1234, 2'd0, 2'd2, 1'b1, 32'h8001_1234, 1'b0);
    drain();
    chk("err_cnt_before", 64'(err_cnt32), 64'd0);
    send32(32'h8001_1234, 2'd1, 2'd1, 1'b0, 32'h0, 1'b1);
    drain();
    chk("err_cnt_misalign", 64'(err_cnt32), 64'd1);
    send32(32'h8001_1234, 2'd0, 2'd3, 1'b0, 32'h0, 1'b1);
    drain();
    chk("err_cnt_size3", 64'(err_cnt32), 64'd2);

    send64(64'h0102_0304_0506_0708, 3'd4, 2'd2, 1'b0, 64'h0000_0000_0506_0708, 1'b0);
    send64(64'h0102_0304_0506_0708, 3'd0, 2'd0, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
    send64(64'h8899_AABB_CCDD_EEFF, 3'd6, 2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_EEFF, 1'b0);
    send64(64'h8899_AABB_CCDD_EEFF, 3'd0, 2'd2, 1'b1, 64'hFFFF_FFFF_8899_AABB, 1'b0);
    send64(64'h8899_AABB_CCDD_EEFF, 3'd0, 2'd3, 1'b1, 64'h8899_AABB_CCDD_EEFF, 1'b0);
    send64(64'h8899_AABB_CCDD_EEFF, 3'd2, 2'd2, 1'b0, 64'h0, 1'b1);
    drain();
    chk("err_cnt64", 64'(err_cnt64), 64'd1);

    out_ready32 = 1'b0;
    send32(32'h1122_3344, 2'd0, 2'd2, 1'b0, 32'h1122_3344, 1'b0);
    send32(32'h1122_3344, 2'd3, 2'd0, 1'b0, 32'h0000_0011, 1'b0);
    chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
    repeat (3) @(negedge clk);
    out_ready32 = 1'b1;
    drain();
    chk("bp_in_ready_back", 64'(in_ready32), 64'd1);

    out_ready32 = 1'b0;
    send32(32'hAAAA_5555, 2'd0, 2'd2, 1'b0, 32'hAAAA_5555, 1'b0);
    send32(32'hAAAA_5555, 2'd1, 2'd1, 1'b0, 32'h0, 1'b1);
    chk("two_in_ready", 64'(in_ready32), 64'd0);
    rst = 1'b1;
    #4;
    chk("rstmid_in_ready", 64'(in_ready32), 64'd0);
    q32.delete();
    @(negedge clk);
    chk("rstmid_out_valid", 64'(out_valid32), 64'd0);
    chk("rstmid_err_cnt", 64'(err_cnt32), 64'd0);
    rst = 1'b0;
    out_ready32 = 1'b1;
    send32(32'h0000_C000, 2'd0, 2'd1, 1'b1, 32'hFFFF_C000, 1'b0);
    chk("rstmid_latency", 64'(out_valid32), 64'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
